// File: rtl/pattern_pkg.sv
// Shared pattern definitions for the pattern transmitter and detector.
// Holds FSM encodings, fixed pattern words and source select codes.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_P4   = 2'b01,
    SEL_P5   = 2'b10,
    SEL_USER = 2'b11
  } sel_t;

  localparam logic [7:0] P4_WORD = 8'b0000_0100;
  localparam logic [3:0] P4_LEN  = 4'd4;
  localparam logic [7:0] P5_WORD = 8'b0000_0010;
  localparam logic [3:0] P5_LEN  = 4'd5;
  localparam logic [3:0] MAX_LEN = 4'd8;

  function automatic logic [3:0] clamp_len(
    input logic [3:0] l
  );
    if (l == 4'd0 || l > MAX_LEN)
      return MAX_LEN;
    return l;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// 8-bit parallel-load shift register, LSB first.
// Load wins over shift; lsb is the next bit to send.
module piso_shift (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       lsb
);

  logic [7:0] q;

  always_ff @(posedge clk) begin
    if (!reset)
      q <= '0;
    else if (load)
      q <= din;
    else if (shift)
      q <= {1'b0, q[7:1]};
  end

  assign lsb = q[0];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: P4, P5 or a user word, LSB first,
// followed by an idle gap and a one-cycle done pulse.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int   GAP_BITS = 2,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [7:0] data,
  input  logic [3:0] len,
  output logic       sout,
  output logic       busy,
  output logic       done
);

  localparam int GW =
    (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_INIT =
    GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t        state_q, state_n;
  logic [3:0]    cnt_q, cnt_n;
  logic [GW-1:0] gcnt_q, gcnt_n;
  logic          sout_n, busy_n, done_n;
  logic          load, shift, lsb;
  logic [7:0]    din;
  logic [7:0]    word;
  logic [3:0]    wlen;

  always_comb begin
    word = '0;
    wlen = '0;
    unique case (1'b1)
      (sel == SEL_NONE): begin
        word = '0;
        wlen = '0;
      end
      (sel == SEL_P4): begin
        word = P4_WORD;
        wlen = P4_LEN;
      end
      (sel == SEL_P5): begin
        word = P5_WORD;
        wlen = P5_LEN;
      end
      (sel == SEL_USER): begin
        word = data;
        wlen = clamp_len(len);
      end
    endcase
  end

  // Bit 0 goes straight to sout; the rest
  // are loaded for later shifting.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    gcnt_n  = gcnt_q;
    sout_n  = IDLE_BIT;
    load    = 1'b0;
    shift   = 1'b0;
    din     = '0;
    case (state_q)
      IDLE: begin
        if (start && sel != SEL_NONE) begin
          load    = 1'b1;
          din     = {1'b0, word[7:1]};
          sout_n  = word[0];
          cnt_n   = wlen - 4'd1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 4'd0) begin
          gcnt_n  = GAP_INIT;
          state_n = (GAP_BITS > 0) ? GAP : DONE;
        end else begin
          shift  = 1'b1;
          sout_n = lsb;
          cnt_n  = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (gcnt_q == '0)
          state_n = DONE;
        else
          gcnt_n = gcnt_q - 1'b1;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == SHIFT) ||
             (state_n == GAP);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      sout    <= IDLE_BIT;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      gcnt_q  <= gcnt_n;
      sout    <= sout_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  piso_shift u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (din),
    .lsb   (lsb)
  );

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: directed cases plus
// randomized frames against a per-cycle expected-trace model.
module tb_pattern_tx;

  localparam int   GAP = 2;
  localparam logic IDL = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] sel;
  logic [7:0] data;
  logic [3:0] len;
  logic       sout, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  int p4[4] = '{0, 0, 1, 0};
  int p5[5] = '{0, 1, 0, 0, 0};

  always #5 clk = ~clk;

  pattern_tx #(
    .GAP_BITS (GAP),
    .IDLE_BIT (IDL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sel   (sel),
    .data  (data),
    .len   (len),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h want=%0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs();
    return {29'd0, sout, busy, done};
  endfunction

  // mode 0: quiet inputs during the frame
  // mode 1: random inputs during the frame
  // mode 2: hold start with sel=P4 during the frame
  task automatic frame(
    input string      tag,
    input logic [1:0] s,
    input logic [7:0] d,
    input logic [3:0] l,
    input int         mode
  );
    logic [2:0] exp[$];
    int n;
    int last_busy;
    exp = {};
    if (s == 2'd1)
      foreach (p4[i])
        exp.push_back({1'(p4[i]), 2'b10});
    else if (s == 2'd2)
      foreach (p5[i])
        exp.push_back({1'(p5[i]), 2'b10});
    else if (s == 2'd3) begin
      n = (l == 0 || l > 8) ? 8 : int'(l);
      for (int i = 0; i < n; i++)
        exp.push_back({1'(d >> i), 2'b10});
    end
    if (s != 2'd0) begin
      for (int i = 0; i < GAP; i++)
        exp.push_back({IDL, 2'b10});
      exp.push_back({IDL, 2'b01});
    end
    last_busy = exp.size() - 1;
    exp.push_back({IDL, 2'b00});
    exp.push_back({IDL, 2'b00});
    sel   = s;
    data  = d;
    len   = l;
    start = 1'b1;
    step();
    for (int k = 0; k < exp.size(); k++) begin
      chk($sformatf("%s[%0d]", tag, k),
          obs(), {29'd0, exp[k]});
      if (k <= last_busy && s != 2'd0 &&
          mode == 1) begin
        start = 1'($urandom);
        sel   = 2'($urandom);
        data  = 8'($urandom);
        len   = 4'($urandom);
      end else if (k <= last_busy &&
                   s != 2'd0 && mode == 2) begin
        start = 1'b1;
        sel   = 2'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    sel   = 2'd0;
    data  = 8'd0;
    len   = 4'd0;
    step();
    step();
    chk("reset", obs(), {29'd0, IDL, 2'b00});
    reset = 1'b1;
    step();
    chk("post_reset", obs(), {29'd0, IDL, 2'b00});

    frame("p4", 2'd1, 8'h00, 4'd0, 0);
    frame("p5", 2'd2, 8'h00, 4'd0, 0);
    frame("a5_l8", 2'd3, 8'hA5, 4'd8, 0);
    frame("a5_l0", 2'd3, 8'hA5, 4'd0, 0);
    frame("p5_poke", 2'd2, 8'h00, 4'd0, 2);
    frame("none", 2'd0, 8'h5A, 4'd3, 0);
    frame("u_l1", 2'd3, 8'h01, 4'd1, 0);
    frame("u_l15", 2'd3, 8'h3C, 4'd15, 1);

    // abort a user frame at its second bit
    sel   = 2'd3;
    data  = 8'b1010_1010;
    len   = 4'd6;
    start = 1'b1;
    step();
    chk("abort_b0", obs(), {29'd0, 1'b0, 2'b10});
    start = 1'b0;
    step();
    chk("abort_b1", obs(), {29'd0, 1'b1, 2'b10});
    reset = 1'b0;
    step();
    chk("abort_rst", obs(), {29'd0, IDL, 2'b00});
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("abort_idle[%0d]", i),
          obs(), {29'd0, IDL, 2'b00});
    end

    // reset wins over start
    reset = 1'b0;
    start = 1'b1;
    sel   = 2'd1;
    step();
    chk("rst_prio", obs(), {29'd0, IDL, 2'b00});
    reset = 1'b1;
    start = 1'b0;
    step();
    chk("rst_prio2", obs(), {29'd0, IDL, 2'b00});

    for (int t = 0; t < 40; t++)
      frame($sformatf("rnd%0d", t),
            2'($urandom), 8'($urandom),
            4'($urandom), int'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The block SHALL have parameter GAP_BITS, default 2, giving the number of idle-level bits driven after each frame.
REQ-002 The block SHALL have parameter IDLE_BIT, default 1'b1, giving the serial line level when no frame bit is being driven.
REQ-003 The block SHALL have port clk, input, 1, the clock; all state updates on posedge so the line is stable at the far-end negedge sample.
REQ-004 The block SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, a frame request sampled on posedge.
REQ-006 The block SHALL have port sel, input, 2, the frame source: 00 none, 01 pattern P4, 10 pattern P5, 11 user word.
REQ-007 The block SHALL have port data, input, 8, the user word, used only when sel=11.
REQ-008 The block SHALL have port len, input, 4, the user word bit count, used only when sel=11.
REQ-009 The block SHALL have port sout, output, 1, the serial line.
REQ-010 The block SHALL have port busy, output, 1, high while a frame or its gap is in progress.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse at frame completion.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, GAP and DONE.
REQ-013 In IDLE, start=1 with sel!=00 SHALL latch the source word and length into a shift register and bit counter, and enter SHIFT.
REQ-014 In IDLE, start=1 with sel=00 SHALL be ignored: the block stays in IDLE and issues no done pulse.
REQ-015 P4 SHALL be the word 4'b0100 with length 4, and P5 SHALL be the word 5'b00010 with length 5.
REQ-016 Bits SHALL be sent LSB (rightmost) first, so P4 goes out as 0,0,1,0 and P5 as 0,1,0,0,0.
REQ-017 For sel=11, a len value of 1..8 SHALL be used as given, and len values of 0 or 9..15 SHALL be clamped to 8.
REQ-018 Latency SHALL be one cycle: bit0 appears on sout at the first posedge after start is sampled, and busy rises on the same edge.
REQ-019 Each bit SHALL be held for exactly one clock period.
REQ-020 After the last bit, the block SHALL enter GAP and drive IDLE_BIT for GAP_BITS cycles; with GAP_BITS=0, GAP is skipped.
REQ-021 DONE SHALL last one cycle with done=1, busy=0 and sout=IDLE_BIT, and SHALL then return to IDLE.
REQ-022 A start that coincides with DONE SHALL be ignored; a new frame can begin from IDLE only.
REQ-023 start, sel, data and len SHALL be ignored while busy=1, and changes to them during a frame SHALL NOT affect that frame.
REQ-024 sout SHALL be registered and glitch-free, and SHALL equal IDLE_BIT in IDLE, GAP and DONE.
REQ-025 The bit counter SHALL be 4 bits wide, SHALL count down to zero, and SHALL NOT wrap.

Reset
REQ-026 reset=0 at a posedge SHALL force state IDLE, sout=IDLE_BIT, busy=0, done=0, and clear the shift register and counter.
REQ-027 Reset asserted mid-frame SHALL abort the frame: sout returns to IDLE_BIT on that edge and no done pulse is issued.
REQ-028 Reset SHALL take priority over a simultaneous start.

Structure
REQ-029 The state encodings, the P4/P5 words and lengths, and the sel codes SHALL reside in the shared package pattern_pkg, where the detector-side block also gets them.
REQ-030 One sub-module, piso_shift (8-bit parallel-load LSB-first shift register with load and shift enables), SHALL be instantiated; the FSM and counter stay in pattern_tx.

Verification
REQ-031 Apply reset=0 for 2 cycles, then sel=01 with start pulsed -> sout=0,0,1,0,1,1, then a done pulse; busy high for 6 cycles.
REQ-032 Start with sel=10 -> sout=0,1,0,0,0 followed by 2 idle bits, then done.
REQ-033 Start with sel=11, data=8'hA5, len=8 -> sout=1,0,1,0,0,1,0,1; then repeat with len=0 -> the same 8 bits (clamp).
REQ-034 Pulse start again with sel=01 at the 3rd bit of a P5 frame -> the P5 frame completes unchanged and no P4 follows.
REQ-035 Assert reset=0 at the 2nd bit of a user frame -> sout=IDLE_BIT, busy=0, and no done pulse.
REQ-036 Start with sel=00 -> busy stays 0, no done, and sout stays at IDLE_BIT.
